// File: rtl/uart_pkg.sv
// Shared constants for the configurable UART receiver: state encoding,
// parity modes, oversampling counts and the majority-vote helper.
package uart_pkg;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_DATA      = 3'd2;
    localparam logic [2:0] ST_PARITY    = 3'd3;
    localparam logic [2:0] ST_STOP      = 3'd4;
    localparam logic [2:0] ST_WAIT_HIGH = 3'd5;

    typedef enum logic [2:0] {
        StIdle     = ST_IDLE,
        StStart    = ST_START,
        StData     = ST_DATA,
        StParity   = ST_PARITY,
        StStop     = ST_STOP,
        StWaitHigh = ST_WAIT_HIGH
    } rx_state_e;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_ODD  = 1;
    localparam int unsigned PAR_EVEN = 2;

    // Oversample counts within one 16-strobe bit time
    localparam logic [3:0] CNT_S6   = 4'd6;
    localparam logic [3:0] CNT_S7   = 4'd7;
    localparam logic [3:0] CNT_S8   = 4'd8;
    localparam logic [3:0] CNT_LAST = 4'd15;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Input synchroniser and 3-sample majority vote for the UART receiver.
// Samples 6 and 7 are held; sample 8 is the live synchronised value, so
// maj_o is valid on the strobe that sees count 8.
module uart_rx_sampler
    import uart_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       brg_stb_i,
    input  logic [3:0] brg_cnt_i,
    input  logic       din_i,
    output logic       rxd_o,
    output logic       maj_o
);

    logic [1:0] sync_q;
    logic       s6_q;
    logic       s7_q;

    // Two-flop synchroniser, resets to the idle-high line level
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], din_i};
        end
    end

    assign rxd_o = sync_q[1];

    // Capture the early samples of the bit on their strobes
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            s6_q <= 1'b1;
            s7_q <= 1'b1;
        end else if (brg_stb_i) begin
            if (brg_cnt_i == CNT_S6) s6_q <= rxd_o;
            if (brg_cnt_i == CNT_S7) s7_q <= rxd_o;
        end
    end

    assign maj_o = maj3(s6_q, s7_q, rxd_o);

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable 16x-oversampling UART receiver: data width, parity mode and
// stop-bit count are parameters. Reports parity, framing and break status.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned PARITY    = 0,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 brg_stb_i,
    input  logic                 din_i,
    output logic [DATA_BITS-1:0] dout_o,
    output logic                 done_stb_o,
    output logic                 parity_err_o,
    output logic                 frame_err_o,
    output logic                 break_o
);

    localparam logic [3:0] LAST_BIT  = 4'(DATA_BITS - 1);
    localparam logic       LAST_STOP = (STOP_BITS == 2) ? 1'b1 : 1'b0;

    rx_state_e            state_q;
    logic [3:0]           cnt_q;
    logic [3:0]           bit_q;
    logic                 stop_q;
    logic [DATA_BITS-1:0] shreg_q;
    logic                 par_err_q;
    logic                 ferr_q;
    logic                 one_q;   // any data/parity/stop majority was 1
    logic [DATA_BITS-1:0] dout_q;
    logic                 done_q;
    logic                 perr_out_q;
    logic                 ferr_out_q;
    logic                 brk_out_q;

    logic rxd;
    logic maj;
    logic s8;
    logic s15;
    logic par_exp;

    uart_rx_sampler u_sampler (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .brg_stb_i (brg_stb_i),
        .brg_cnt_i (cnt_q),
        .din_i     (din_i),
        .rxd_o     (rxd),
        .maj_o     (maj)
    );

    assign s8      = brg_stb_i && (cnt_q == CNT_S8);
    assign s15     = brg_stb_i && (cnt_q == CNT_LAST);
    assign par_exp = (PARITY == PAR_EVEN) ? ^shreg_q : ~^shreg_q;

    // Frame FSM with shift register, error tracking and registered outputs
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            cnt_q      <= 4'd0;
            bit_q      <= 4'd0;
            stop_q     <= 1'b0;
            shreg_q    <= '0;
            par_err_q  <= 1'b0;
            ferr_q     <= 1'b0;
            one_q      <= 1'b0;
            dout_q     <= '0;
            done_q     <= 1'b0;
            perr_out_q <= 1'b0;
            ferr_out_q <= 1'b0;
            brk_out_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (brg_stb_i) cnt_q <= cnt_q + 4'd1;
            case (state_q)
                StIdle: begin
                    // Start edge needs no strobe; counting restarts here
                    if (!rxd) begin
                        cnt_q     <= 4'd0;
                        bit_q     <= 4'd0;
                        stop_q    <= 1'b0;
                        par_err_q <= 1'b0;
                        ferr_q    <= 1'b0;
                        one_q     <= 1'b0;
                        state_q   <= StStart;
                    end
                end
                StStart: begin
                    if (s8 && maj) begin
                        state_q <= StIdle;
                    end else if (s15) begin
                        bit_q   <= 4'd0;
                        state_q <= StData;
                    end
                end
                StData: begin
                    if (s8) begin
                        shreg_q <= {maj, shreg_q[DATA_BITS-1:1]};
                        if (maj) one_q <= 1'b1;
                    end
                    if (s15) begin
                        if (bit_q == LAST_BIT) begin
                            state_q <= (PARITY != PAR_NONE) ? StParity : StStop;
                        end else begin
                            bit_q <= bit_q + 4'd1;
                        end
                    end
                end
                StParity: begin
                    if (s8) begin
                        par_err_q <= maj ^ par_exp;
                        if (maj) one_q <= 1'b1;
                    end
                    if (s15) state_q <= StStop;
                end
                StStop: begin
                    if (s8) begin
                        if (!maj) ferr_q <= 1'b1;
                        if (maj) one_q <= 1'b1;
                        // Final stop bit: commit mid-bit so the next start edge is caught
                        if (stop_q == LAST_STOP) begin
                            dout_q     <= shreg_q;
                            perr_out_q <= par_err_q;
                            ferr_out_q <= ferr_q | ~maj;
                            brk_out_q  <= ~(one_q | maj);
                            done_q     <= 1'b1;
                            state_q    <= maj ? StIdle : StWaitHigh;
                        end
                    end else if (s15) begin
                        stop_q <= 1'b1;
                    end
                end
                StWaitHigh: begin
                    if (rxd) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign dout_o       = dout_q;
    assign done_stb_o   = done_q;
    assign parity_err_o = perr_out_q;
    assign frame_err_o  = ferr_out_q;
    assign break_o      = brk_out_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: three instances (8-N-1, 7-E-1, 8-N-2) share clock,
// reset and strobe; expected frames are queued when sent and popped when
// the matching instance strobes done.
module tb_uart_rx_cfg;

    logic clk;
    logic rst_n;
    logic stb;
    logic din0, din1, din2;

    logic [7:0] d0;
    logic [6:0] d1;
    logic [7:0] d2;
    logic done0, done1, done2;
    logic pe0, pe1, pe2;
    logic fe0, fe1, fe2;
    logic bk0, bk1, bk2;

    uart_rx_cfg #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_n1 (
        .clk_i(clk), .rst_ni(rst_n), .brg_stb_i(stb), .din_i(din0), .dout_o(d0),
        .done_stb_o(done0), .parity_err_o(pe0), .frame_err_o(fe0), .break_o(bk0)
    );

    uart_rx_cfg #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) u_e1 (
        .clk_i(clk), .rst_ni(rst_n), .brg_stb_i(stb), .din_i(din1), .dout_o(d1),
        .done_stb_o(done1), .parity_err_o(pe1), .frame_err_o(fe1), .break_o(bk1)
    );

    uart_rx_cfg #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_n2 (
        .clk_i(clk), .rst_ni(rst_n), .brg_stb_i(stb), .din_i(din2), .dout_o(d2),
        .done_stb_o(done2), .parity_err_o(pe2), .frame_err_o(fe2), .break_o(bk2)
    );

    typedef struct packed {
        logic [8:0] d;
        logic       pe;
        logic       fe;
        logic       bk;
    } exp_t;

    typedef struct {
        int         inst;
        logic [8:0] data;
        logic       par;
        logic [1:0] stops;  // bit0 = first stop bit
        int         noise;  // data bit index carrying a one-strobe glitch, -1 none
        int         gap;    // idle bit times after the frame
        exp_t       exp;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs[NV];
    exp_t q0[$], q1[$], q2[$];
    int checks = 0;
    int errors = 0;
    int seen0 = 0, seen1 = 0, seen2 = 0;
    int pushed0 = 0, pushed1 = 0, pushed2 = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Strobe every 4th clock: never on consecutive cycles
    initial begin
        int phase;
        phase = 0;
        stb   = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            stb   = (phase == 3);
            phase = (phase + 1) % 4;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    function automatic exp_t mke(input logic [8:0] d, input logic pe, input logic fe,
                                 input logic bk);
        exp_t e;
        e.d  = d;
        e.pe = pe;
        e.fe = fe;
        e.bk = bk;
        return e;
    endfunction

    function automatic vec_t mk(input int inst, input logic [8:0] data, input logic par,
                                input logic [1:0] stops, input int noise, input int gap,
                                input exp_t e);
        vec_t v;
        v.inst  = inst;
        v.data  = data;
        v.par   = par;
        v.stops = stops;
        v.noise = noise;
        v.gap   = gap;
        v.exp   = e;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [8:0] got, input logic [8:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
        end
    endtask

    task automatic check_done(input int inst, input logic [8:0] d, input logic pe,
                              input logic fe, input logic bk);
        exp_t e;
        int   n;
        n = (inst == 0) ? q0.size() : (inst == 1) ? q1.size() : q2.size();
        if (n == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done inst=%0d: got dout=%0h, expected no strobe", inst, d);
        end else begin
            case (inst)
                0:       e = q0.pop_front();
                1:       e = q1.pop_front();
                default: e = q2.pop_front();
            endcase
            chk($sformatf("dout[%0d]", inst), d, e.d);
            chk($sformatf("parity_err[%0d]", inst), 9'(pe), 9'(e.pe));
            chk($sformatf("frame_err[%0d]", inst), 9'(fe), 9'(e.fe));
            chk($sformatf("break[%0d]", inst), 9'(bk), 9'(e.bk));
        end
    endtask

    // Monitors sample away from the active edge
    always @(negedge clk) if (done0) begin seen0++; check_done(0, {1'b0, d0}, pe0, fe0, bk0); end
    always @(negedge clk) if (done1) begin seen1++; check_done(1, {2'b0, d1}, pe1, fe1, bk1); end
    always @(negedge clk) if (done2) begin seen2++; check_done(2, {1'b0, d2}, pe2, fe2, bk2); end

    task automatic push(input int inst, input exp_t e);
        case (inst)
            0:       begin q0.push_back(e); pushed0++; end
            1:       begin q1.push_back(e); pushed1++; end
            default: begin q2.push_back(e); pushed2++; end
        endcase
    endtask

    task automatic wait_clks(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_din(input int inst, input logic v);
        case (inst)
            0:       din0 = v;
            1:       din1 = v;
            default: din2 = v;
        endcase
    endtask

    task automatic send_bit(input int inst, input logic v, input bit noisy);
        set_din(inst, v);
        if (noisy) begin
            wait_clks(30);
            set_din(inst, ~v);
            wait_clks(4);
            set_din(inst, v);
            wait_clks(30);
        end else begin
            wait_clks(64);
        end
    endtask

    task automatic send_frame(input int inst, input logic [8:0] data, input logic par,
                              input logic [1:0] stops, input int noise);
        int nb;
        nb = (inst == 1) ? 7 : 8;
        send_bit(inst, 1'b0, 1'b0);
        for (int i = 0; i < nb; i++) send_bit(inst, data[i], i == noise);
        if (inst == 1) send_bit(inst, par, 1'b0);
        send_bit(inst, stops[0], 1'b0);
        if (inst == 2) send_bit(inst, stops[1], 1'b0);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((q0.size() + q1.size() + q2.size()) != 0 && t < 3000) begin
            @(posedge clk);
            t++;
        end
        checks++;
        if ((q0.size() + q1.size() + q2.size()) != 0) begin
            errors++;
            $display("FAIL done_timeout: got %0d/%0d/%0d frames pending, expected 0",
                     q0.size(), q1.size(), q2.size());
            q0.delete();
            q1.delete();
            q2.delete();
        end
    endtask

    initial begin
        int nb;
        rst_n = 1'b0;
        din0  = 1'b1;
        din1  = 1'b1;
        din2  = 1'b1;

        vecs[0]  = mk(0, 9'h0A5, 1'b0, 2'b11, -1, 2, mke(9'h0A5, 0, 0, 0));
        vecs[1]  = mk(1, 9'h055, 1'b1, 2'b11, -1, 2, mke(9'h055, 1, 0, 0));
        vecs[2]  = mk(1, 9'h055, 1'b0, 2'b11, -1, 0, mke(9'h055, 0, 0, 0));
        vecs[3]  = mk(1, 9'h07F, 1'b1, 2'b11, -1, 0, mke(9'h07F, 0, 0, 0));
        vecs[4]  = mk(1, 9'h003, 1'b1, 2'b11, -1, 2, mke(9'h003, 1, 0, 0));
        vecs[5]  = mk(0, 9'h000, 1'b0, 2'b11,  3, 2, mke(9'h000, 0, 0, 0));
        vecs[6]  = mk(0, 9'h0FF, 1'b0, 2'b11, -1, 0, mke(9'h0FF, 0, 0, 0));
        vecs[7]  = mk(0, 9'h05A, 1'b0, 2'b11, -1, 2, mke(9'h05A, 0, 0, 0));
        vecs[8]  = mk(2, 9'h03C, 1'b0, 2'b01, -1, 2, mke(9'h03C, 0, 1, 0));
        vecs[9]  = mk(2, 9'h03C, 1'b0, 2'b11, -1, 0, mke(9'h03C, 0, 0, 0));
        vecs[10] = mk(2, 9'h0C3, 1'b0, 2'b11, -1, 2, mke(9'h0C3, 0, 0, 0));
        vecs[11] = mk(0, 9'h000, 1'b0, 2'b00, -1, 2, mke(9'h000, 0, 1, 1));
        vecs[12] = mk(2, 9'h000, 1'b0, 2'b10, -1, 2, mke(9'h000, 0, 1, 0));

        wait_clks(6);
        chk("reset_dout0", {1'b0, d0}, 9'h000);
        chk("reset_done0", 9'(done0), 9'h000);
        chk("reset_flags0", {6'b0, pe0, fe0, bk0}, 9'h000);
        chk("reset_dout2", {1'b0, d2}, 9'h000);
        rst_n = 1'b1;
        wait_clks(10);

        for (int i = 0; i < NV; i++) begin
            push(vecs[i].inst, vecs[i].exp);
            send_frame(vecs[i].inst, vecs[i].data, vecs[i].par, vecs[i].stops, vecs[i].noise);
            drain();
            set_din(vecs[i].inst, 1'b1);
            wait_clks(64 * vecs[i].gap);
        end

        // False start: short low pulse must not produce a frame
        push(0, mke(9'h096, 0, 0, 0));
        send_frame(0, 9'h096, 1'b0, 2'b11, -1);
        drain();
        set_din(0, 1'b1);
        wait_clks(128);
        set_din(0, 1'b0);
        wait_clks(16);
        set_din(0, 1'b1);
        wait_clks(64 * 3);
        chk("glitch_dout", {1'b0, d0}, 9'h096);
        chk("glitch_flags", {6'b0, pe0, fe0, bk0}, 9'h000);
        push(0, mke(9'h069, 0, 0, 0));
        send_frame(0, 9'h069, 1'b0, 2'b11, -1);
        drain();
        set_din(0, 1'b1);
        wait_clks(128);

        // Break: line low for three frame times gives exactly one strobe
        nb = seen2;
        push(2, mke(9'h000, 0, 1, 1));
        set_din(2, 1'b0);
        wait_clks(64 * 33);
        chk("break_strobes", 9'(seen2 - nb), 9'd1);
        drain();
        set_din(2, 1'b1);
        wait_clks(128);
        push(2, mke(9'h03C, 0, 0, 0));
        send_frame(2, 9'h03C, 1'b0, 2'b11, -1);
        drain();
        set_din(2, 1'b1);
        wait_clks(128);

        // Reset during data bit 4 discards the frame
        send_bit(0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(0, (i == 0), 1'b0);
        set_din(0, 1'b0);
        wait_clks(32);
        rst_n = 1'b0;
        set_din(0, 1'b1);
        wait_clks(3);
        chk("midrst_dout", {1'b0, d0}, 9'h000);
        chk("midrst_done", 9'(done0), 9'h000);
        rst_n = 1'b1;
        wait_clks(128);
        push(0, mke(9'h081, 0, 0, 0));
        send_frame(0, 9'h081, 1'b0, 2'b11, -1);
        drain();
        set_din(0, 1'b1);
        wait_clks(128);

        chk("strobe_count0", 9'(seen0), 9'(pushed0));
        chk("strobe_count1", 9'(seen1), 9'(pushed1));
        chk("strobe_count2", 9'(seen2), 9'(pushed2));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
